reg_bus_master: RTL and testbench

- Initiator side of the register-block port: turns request/response transactions into the write strobes (Addr_In/Data_In) and read lookups (Addr_Out/Data_Out) that a register block consumes.
- Supports auto-incrementing bursts, parks the write address outside the write window when idle, and returns read data through a valid/ready response channel.
- Sits between the control/command front end and one register block.

---
 rtl/reg_bus_master_pkg.sv | 21 ++
 rtl/reg_bus_master.sv | 157 +++++++++++++++
 tb/tb_reg_bus_master.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bus_master_pkg.sv
// Shared definitions for the register-bus initiator and the register block it drives.
package reg_bus_master_pkg;

  localparam int DEF_IN_ADDR_WIDTH  = 7;
  localparam int DEF_OUT_ADDR_WIDTH = 9;
  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_LEN_WIDTH      = 5;

  // All ones sits outside the block's write window, so presenting it is a no-op.
  localparam logic [DEF_IN_ADDR_WIDTH-1:0] PARK_ADDR = '1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_WR_RSP = 3'd2,
    ST_RD_SET = 3'd3,
    ST_RD_CAP = 3'd4,
    ST_RD_RSP = 3'd5
  } state_t;

endpackage

// File: rtl/reg_bus_master.sv
// Initiator for a register block: converts request/write-data/response handshakes
// into write strobes (Addr_In/Data_In) and read lookups (Addr_Out/Data_Out).
module reg_bus_master
  import reg_bus_master_pkg::*;
#(
  parameter int IN_ADDR_WIDTH  = DEF_IN_ADDR_WIDTH,
  parameter int OUT_ADDR_WIDTH = DEF_OUT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH      = DEF_LEN_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Req_Valid,
  output logic                      Req_Ready,
  input  logic                      Req_Write,
  input  logic [OUT_ADDR_WIDTH-1:0] Req_Addr,
  input  logic [LEN_WIDTH-1:0]      Req_Len,
  input  logic                      Wr_Valid,
  output logic                      Wr_Ready,
  input  logic [DATA_WIDTH-1:0]     Wr_Data,
  output logic                      Rsp_Valid,
  input  logic                      Rsp_Ready,
  output logic [DATA_WIDTH-1:0]     Rsp_Data,
  output logic                      Rsp_Last,
  output logic                      Rsp_Err,
  output logic [IN_ADDR_WIDTH-1:0]  Reg_Addr_In,
  output logic [DATA_WIDTH-1:0]     Reg_Data_In,
  output logic [OUT_ADDR_WIDTH-1:0] Reg_Addr_Out,
  input  logic [DATA_WIDTH-1:0]     Reg_Data_Out
);

  localparam logic [IN_ADDR_WIDTH-1:0] ParkAddr = '1;

  state_t                      state_q, state_d;
  logic [OUT_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
  logic                        err_q, err_d;

  logic                        req_ready_d, wr_ready_d, rsp_valid_d;
  logic [DATA_WIDTH-1:0]       rsp_data_d;
  logic                        rsp_last_d, rsp_err_d;
  logic [IN_ADDR_WIDTH-1:0]    addr_in_d;
  logic [DATA_WIDTH-1:0]       data_in_d;
  logic [OUT_ADDR_WIDTH-1:0]   addr_out_d;

  logic req_hs, wr_hs, rsp_hs, in_window, last_beat;

  assign req_hs    = Req_Valid & Req_Ready;
  assign wr_hs     = Wr_Valid & Wr_Ready;
  assign rsp_hs    = Rsp_Valid & Rsp_Ready;
  assign in_window = ~|addr_q[OUT_ADDR_WIDTH-1:IN_ADDR_WIDTH];
  assign last_beat = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_hs) state_d = Req_Write ? ST_WR : ST_RD_SET;
      ST_WR:     if (wr_hs && last_beat) state_d = ST_WR_RSP;
      ST_WR_RSP: if (rsp_hs) state_d = ST_IDLE;
      ST_RD_SET: state_d = ST_RD_CAP;
      ST_RD_CAP: state_d = ST_RD_RSP;
      ST_RD_RSP: if (rsp_hs) state_d = last_beat ? ST_IDLE : ST_RD_SET;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of every registered output; handshake flags follow the next state.
  always_comb begin
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    req_ready_d = (state_d == ST_IDLE);
    wr_ready_d  = (state_d == ST_WR);
    rsp_valid_d = (state_d == ST_WR_RSP) || (state_d == ST_RD_RSP);
    rsp_data_d  = Rsp_Data;
    rsp_last_d  = Rsp_Last;
    rsp_err_d   = Rsp_Err;
    addr_in_d   = ParkAddr;
    data_in_d   = Reg_Data_In;
    addr_out_d  = Reg_Addr_Out;
    case (state_q)
      ST_IDLE: begin
        if (req_hs) begin
          addr_d = Req_Addr;
          cnt_d  = Req_Len;
          err_d  = 1'b0;
        end
      end
      ST_WR: begin
        if (wr_hs) begin
          if (in_window) begin
            addr_in_d = addr_q[IN_ADDR_WIDTH-1:0];
            data_in_d = Wr_Data;
          end else begin
            err_d = 1'b1;
          end
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (last_beat) begin
            rsp_data_d = '0;
            rsp_last_d = 1'b1;
            rsp_err_d  = err_q | ~in_window;
          end
        end
      end
      ST_RD_SET: addr_out_d = addr_q;
      ST_RD_CAP: begin
        rsp_data_d = Reg_Data_Out;
        rsp_last_d = last_beat;
        rsp_err_d  = 1'b0;
      end
      ST_RD_RSP: begin
        if (rsp_hs && !last_beat) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    cnt_q  <= cnt_d;
    err_q  <= err_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Req_Ready    <= 1'b0;
      Wr_Ready     <= 1'b0;
      Rsp_Valid    <= 1'b0;
      Rsp_Data     <= '0;
      Rsp_Last     <= 1'b0;
      Rsp_Err      <= 1'b0;
      Reg_Addr_In  <= ParkAddr;
      Reg_Data_In  <= '0;
      Reg_Addr_Out <= '0;
    end else begin
      Req_Ready    <= req_ready_d;
      Wr_Ready     <= wr_ready_d;
      Rsp_Valid    <= rsp_valid_d;
      Rsp_Data     <= rsp_data_d;
      Rsp_Last     <= rsp_last_d;
      Rsp_Err      <= rsp_err_d;
      Reg_Addr_In  <= addr_in_d;
      Reg_Data_In  <= data_in_d;
      Reg_Addr_Out <= addr_out_d;
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master with a 64-entry register block model attached.
module tb_reg_bus_master;
  import reg_bus_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        Req_Valid, Req_Ready, Req_Write;
  logic [8:0]  Req_Addr;
  logic [4:0]  Req_Len;
  logic        Wr_Valid, Wr_Ready;
  logic [15:0] Wr_Data;
  logic        Rsp_Valid, Rsp_Ready, Rsp_Last, Rsp_Err;
  logic [15:0] Rsp_Data;
  logic [6:0]  Reg_Addr_In;
  logic [15:0] Reg_Data_In;
  logic [8:0]  Reg_Addr_Out;
  logic [15:0] Reg_Data_Out;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  reg_bus_master dut (
    .clk(clk), .rst(rst),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Write(Req_Write),
    .Req_Addr(Req_Addr), .Req_Len(Req_Len),
    .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready), .Wr_Data(Wr_Data),
    .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Data(Rsp_Data),
    .Rsp_Last(Rsp_Last), .Rsp_Err(Rsp_Err),
    .Reg_Addr_In(Reg_Addr_In), .Reg_Data_In(Reg_Data_In),
    .Reg_Addr_Out(Reg_Addr_Out), .Reg_Data_Out(Reg_Data_Out)
  );

  // Register block: 64 words, written whenever Reg_Addr_In[6] is clear, reads 0 outside.
  logic [15:0] regs [0:63];
  logic        mdl_clr;
  always @(posedge clk) begin
    if (mdl_clr) begin
      for (int i = 0; i < 64; i++) regs[i] <= 16'h0;
    end else if (Reg_Addr_In[6] == 1'b0) begin
      regs[Reg_Addr_In[5:0]] <= Reg_Data_In;
    end
  end
  assign Reg_Data_Out = (Reg_Addr_Out < 9'd64) ? regs[Reg_Addr_Out[5:0]] : 16'h0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_write(input logic [8:0] a, input logic [4:0] len,
                           input logic [15:0] d0, input logic [15:0] d1,
                           output logic err);
    Req_Valid = 1'b1; Req_Write = 1'b1; Req_Addr = a; Req_Len = len;
    step();
    Req_Valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      Wr_Valid = 1'b1;
      Wr_Data  = (i == 0) ? d0 : d1;
      step();
    end
    Wr_Valid = 1'b0;
    err = Rsp_Err;
    Rsp_Ready = 1'b1;
    step();
    Rsp_Ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mdl_clr = 1'b1;
    Req_Valid = 0; Req_Write = 0; Req_Addr = '0; Req_Len = '0;
    Wr_Valid = 0; Wr_Data = '0; Rsp_Ready = 0;
    repeat (3) step();
    n_checks++;
    if ({Req_Ready, Wr_Ready, Rsp_Valid, Rsp_Last, Rsp_Err} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000", {Req_Ready, Wr_Ready, Rsp_Valid, Rsp_Last, Rsp_Err});
    else n_pass++;
    n_checks++;
    if (Reg_Addr_In !== PARK_ADDR || Reg_Data_In !== 16'h0 || Reg_Addr_Out !== 9'h0 || Rsp_Data !== 16'h0)
      $display("FAIL reset_data: got ai=%h di=%h ao=%h rd=%h expected ai=7f di=0000 ao=000 rd=0000",
               Reg_Addr_In, Reg_Data_In, Reg_Addr_Out, Rsp_Data);
    else n_pass++;
    rst = 1'b0; mdl_clr = 1'b0;
    step();
    n_checks++;
    if (Req_Ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", Req_Ready);
    else n_pass++;
  endtask

  task automatic test_write_burst();
    Req_Valid = 1; Req_Write = 1; Req_Addr = 9'h01E; Req_Len = 5'd1;
    step();
    Req_Valid = 0;
    n_checks++;
    if ({Req_Ready, Wr_Ready} !== 2'b01 || Reg_Addr_In !== 7'h7F)
      $display("FAIL wr_accept: got rr=%b wr=%b ai=%h expected rr=0 wr=1 ai=7f", Req_Ready, Wr_Ready, Reg_Addr_In);
    else n_pass++;
    Wr_Valid = 1; Wr_Data = 16'hAAAA;
    step();
    n_checks++;
    if (Reg_Addr_In !== 7'h1E || Reg_Data_In !== 16'hAAAA || Wr_Ready !== 1'b1)
      $display("FAIL wr_beat0: got ai=%h di=%h wr=%b expected ai=1e di=aaaa wr=1", Reg_Addr_In, Reg_Data_In, Wr_Ready);
    else n_pass++;
    Wr_Data = 16'h5555;
    step();
    Wr_Valid = 0;
    n_checks++;
    if (Reg_Addr_In !== 7'h1F || Reg_Data_In !== 16'h5555 || Wr_Ready !== 1'b0)
      $display("FAIL wr_beat1: got ai=%h di=%h wr=%b expected ai=1f di=5555 wr=0", Reg_Addr_In, Reg_Data_In, Wr_Ready);
    else n_pass++;
    n_checks++;
    if ({Rsp_Valid, Rsp_Last, Rsp_Err} !== 3'b110 || Rsp_Data !== 16'h0)
      $display("FAIL wr_rsp: got v/l/e=%b data=%h expected 110 data=0000", {Rsp_Valid, Rsp_Last, Rsp_Err}, Rsp_Data);
    else n_pass++;
    Rsp_Ready = 1;
    step();
    Rsp_Ready = 0;
    n_checks++;
    if (Reg_Addr_In !== 7'h7F || Rsp_Valid !== 1'b0 || Req_Ready !== 1'b1)
      $display("FAIL wr_done: got ai=%h rv=%b rr=%b expected ai=7f rv=0 rr=1", Reg_Addr_In, Rsp_Valid, Req_Ready);
    else n_pass++;
    n_checks++;
    if (regs[30] !== 16'hAAAA || regs[31] !== 16'h5555)
      $display("FAIL wr_contents: got r1e=%h r1f=%h expected aaaa 5555", regs[30], regs[31]);
    else n_pass++;
  endtask

  task automatic test_window_error();
    Req_Valid = 1; Req_Write = 1; Req_Addr = 9'h07F; Req_Len = 5'd1;
    step();
    Req_Valid = 0;
    Wr_Valid = 1; Wr_Data = 16'h1111;
    step();
    n_checks++;
    if (Reg_Addr_In !== 7'h7F || Reg_Data_In !== 16'h1111)
      $display("FAIL win_beat7f: got ai=%h di=%h expected ai=7f di=1111", Reg_Addr_In, Reg_Data_In);
    else n_pass++;
    Wr_Data = 16'h2222;
    step();
    Wr_Valid = 0;
    n_checks++;
    if (Reg_Addr_In !== 7'h7F || Reg_Data_In !== 16'h1111)
      $display("FAIL win_beat80_parked: got ai=%h di=%h expected ai=7f di=1111", Reg_Addr_In, Reg_Data_In);
    else n_pass++;
    n_checks++;
    if ({Rsp_Valid, Rsp_Last, Rsp_Err} !== 3'b111)
      $display("FAIL win_rsp_err: got v/l/e=%b expected 111", {Rsp_Valid, Rsp_Last, Rsp_Err});
    else n_pass++;
    Rsp_Ready = 1;
    step();
    Rsp_Ready = 0;
    n_checks++;
    if (regs[0] !== 16'h0) $display("FAIL win_no_wrap_write: got r00=%h expected 0000", regs[0]);
    else n_pass++;
  endtask

  task automatic test_preload();
    logic e0, e1;
    run_write(9'h005, 5'd1, 16'h1234, 16'hBEEF, e0);
    run_write(9'h000, 5'd0, 16'hC0DE, 16'h0000, e1);
    n_checks++;
    if ({e0, e1} !== 2'b00 || regs[5] !== 16'h1234 || regs[6] !== 16'hBEEF || regs[0] !== 16'hC0DE)
      $display("FAIL preload: got err=%b r5=%h r6=%h r0=%h expected 00 1234 beef c0de", {e0, e1}, regs[5], regs[6], regs[0]);
    else n_pass++;
  endtask

  task automatic test_read_burst();
    Req_Valid = 1; Req_Write = 0; Req_Addr = 9'h005; Req_Len = 5'd1;
    step();
    Req_Valid = 0;
    for (int c = 1; c <= 2; c++) begin
      n_checks++;
      if (Rsp_Valid !== 1'b0) $display("FAIL rd_latency_c%0d: got rv=%b expected 0", c, Rsp_Valid);
      else n_pass++;
      step();
    end
    n_checks++;
    if (Rsp_Valid !== 1'b1 || Rsp_Data !== 16'h1234 || Rsp_Last !== 1'b0 || Rsp_Err !== 1'b0 || Reg_Addr_Out !== 9'h005)
      $display("FAIL rd_beat0: got v=%b d=%h l=%b e=%b ao=%h expected 1 1234 0 0 005",
               Rsp_Valid, Rsp_Data, Rsp_Last, Rsp_Err, Reg_Addr_Out);
    else n_pass++;
    Rsp_Ready = 1;
    step();
    Rsp_Ready = 0;
    step();
    step();
    n_checks++;
    if (Rsp_Valid !== 1'b1 || Rsp_Data !== 16'hBEEF || Rsp_Last !== 1'b1 || Reg_Addr_Out !== 9'h006)
      $display("FAIL rd_beat1: got v=%b d=%h l=%b ao=%h expected 1 beef 1 006", Rsp_Valid, Rsp_Data, Rsp_Last, Reg_Addr_Out);
    else n_pass++;
    Rsp_Ready = 1;
    step();
    Rsp_Ready = 0;
    n_checks++;
    if (Rsp_Valid !== 1'b0 || Req_Ready !== 1'b1)
      $display("FAIL rd_done: got rv=%b rr=%b expected 0 1", Rsp_Valid, Req_Ready);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    Req_Valid = 1; Req_Write = 0; Req_Addr = 9'h01E; Req_Len = 5'd0;
    step();
    Req_Valid = 0;
    step();
    step();
    // A competing write request is offered while the response is stalled.
    Req_Valid = 1; Req_Write = 1; Req_Addr = 9'h000; Req_Len = 5'd0;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (Rsp_Valid !== 1'b1 || Rsp_Data !== 16'hAAAA || Rsp_Last !== 1'b1 || Reg_Addr_Out !== 9'h01E || Req_Ready !== 1'b0)
        $display("FAIL bp_hold_c%0d: got v=%b d=%h l=%b ao=%h rr=%b expected 1 aaaa 1 01e 0",
                 c, Rsp_Valid, Rsp_Data, Rsp_Last, Reg_Addr_Out, Req_Ready);
      else n_pass++;
      step();
    end
    Req_Valid = 0;
    Rsp_Ready = 1;
    step();
    Rsp_Ready = 0;
    n_checks++;
    if (Req_Ready !== 1'b1 || Wr_Ready !== 1'b0 || Rsp_Valid !== 1'b0)
      $display("FAIL bp_release: got rr=%b wr=%b rv=%b expected 1 0 0", Req_Ready, Wr_Ready, Rsp_Valid);
    else n_pass++;
  endtask

  task automatic test_wrap();
    Req_Valid = 1; Req_Write = 0; Req_Addr = 9'h1FF; Req_Len = 5'd1;
    step();
    Req_Valid = 0;
    step();
    step();
    n_checks++;
    if (Rsp_Valid !== 1'b1 || Rsp_Data !== 16'h0 || Rsp_Last !== 1'b0 || Rsp_Err !== 1'b0 || Reg_Addr_Out !== 9'h1FF)
      $display("FAIL wrap_beat0: got v=%b d=%h l=%b e=%b ao=%h expected 1 0000 0 0 1ff",
               Rsp_Valid, Rsp_Data, Rsp_Last, Rsp_Err, Reg_Addr_Out);
    else n_pass++;
    Rsp_Ready = 1;
    step();
    Rsp_Ready = 0;
    step();
    step();
    n_checks++;
    if (Rsp_Valid !== 1'b1 || Rsp_Data !== 16'hC0DE || Rsp_Last !== 1'b1 || Rsp_Err !== 1'b0 || Reg_Addr_Out !== 9'h000)
      $display("FAIL wrap_beat1: got v=%b d=%h l=%b e=%b ao=%h expected 1 c0de 1 0 000",
               Rsp_Valid, Rsp_Data, Rsp_Last, Rsp_Err, Reg_Addr_Out);
    else n_pass++;
    Rsp_Ready = 1;
    step();
    Rsp_Ready = 0;
  endtask

  task automatic test_reset_mid_burst();
    Req_Valid = 1; Req_Write = 1; Req_Addr = 9'h003; Req_Len = 5'd3;
    step();
    Req_Valid = 0;
    Wr_Valid = 1; Wr_Data = 16'h0303;
    step();
    Wr_Data = 16'h0404;
    step();
    rst = 1; Wr_Data = 16'h0505;
    step();
    n_checks++;
    if (Reg_Addr_In !== 7'h7F || Rsp_Valid !== 1'b0 || Wr_Ready !== 1'b0 || Req_Ready !== 1'b0)
      $display("FAIL rst_mid: got ai=%h rv=%b wr=%b rr=%b expected 7f 0 0 0", Reg_Addr_In, Rsp_Valid, Wr_Ready, Req_Ready);
    else n_pass++;
    rst = 0; Wr_Valid = 0;
    step();
    step();
    n_checks++;
    if (Req_Ready !== 1'b1 || Wr_Ready !== 1'b0 || Reg_Addr_In !== 7'h7F)
      $display("FAIL rst_mid_idle: got rr=%b wr=%b ai=%h expected 1 0 7f", Req_Ready, Wr_Ready, Reg_Addr_In);
    else n_pass++;
    n_checks++;
    if (regs[3] !== 16'h0303 || regs[4] !== 16'h0404 || regs[5] !== 16'h1234 || regs[6] !== 16'hBEEF)
      $display("FAIL rst_mid_contents: got r3=%h r4=%h r5=%h r6=%h expected 0303 0404 1234 beef",
               regs[3], regs[4], regs[5], regs[6]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_window_error();
    test_preload();
    test_read_burst();
    test_backpressure();
    test_wrap();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
